// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin arbiter giving two requesters four-phase access to a shared single-port RAM bus.
module ram_arbiter #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_a,
    input  logic              req_b,
    input  logic              we_a,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_a,
    input  logic [DATA_W-1:0] wdata_b,
    output logic              gnt_a,
    output logic              gnt_b,
    output logic              done_a,
    output logic              done_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    output logic              ram_we,
    output logic              ram_enable,
    output logic [ADDR_W-1:0] ram_addr,
    inout  wire  [DATA_W-1:0] ram_data
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
    state_t state, state_nx;
    logic owner_b, last_b, we_l, pick_b;
    logic [DATA_W-1:0] wdata_l;

    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else       state <= state_nx;

    always_comb begin
        pick_b   = (req_a && req_b) ? !last_b : req_b;
        state_nx = state == IDLE   ? ((req_a || req_b) ? SETUP : IDLE) :
                   state == SETUP  ? ACCESS :
                   state == ACCESS ? RESP : IDLE;
        gnt_a    = state == SETUP && !owner_b;
        gnt_b    = state == SETUP && owner_b;
        done_a   = state == RESP && !owner_b;
        done_b   = state == RESP && owner_b;
    end

    // Strobes are registered from the SETUP phase so they are clean for the whole ACCESS cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_b    <= 1'b0;
            last_b     <= 1'b1;
            we_l       <= 1'b0;
            wdata_l    <= '0;
            ram_addr   <= '0;
            ram_we     <= 1'b0;
            ram_enable <= 1'b0;
            rdata_a    <= '0;
            rdata_b    <= '0;
        end else begin
            if (state == IDLE && (req_a || req_b)) begin
                owner_b  <= pick_b;
                last_b   <= pick_b;
                we_l     <= pick_b ? we_b : we_a;
                ram_addr <= pick_b ? addr_b : addr_a;
                wdata_l  <= pick_b ? wdata_b : wdata_a;
            end
            ram_we     <= state == SETUP && we_l;
            ram_enable <= state == SETUP && !we_l;
            if (state == ACCESS && !we_l && owner_b)  rdata_b <= ram_data;
            if (state == ACCESS && !we_l && !owner_b) rdata_a <= ram_data;
        end
    end

    assign ram_data = (state != IDLE && we_l) ? wdata_l : {DATA_W{1'bz}};
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: randomized and directed checks of ram_arbiter against a transaction-level model with an attached RAM.
module tb_ram_arbiter;
    logic clk = 0, reset = 1;
    logic req_a = 0, req_b = 0, we_a = 0, we_b = 0;
    logic [3:0] addr_a = 0, addr_b = 0;
    logic [7:0] wdata_a = 0, wdata_b = 0;
    logic gnt_a, gnt_b, done_a, done_b, ram_we, ram_enable;
    logic [7:0] rdata_a, rdata_b;
    logic [3:0] ram_addr;
    wire  [7:0] ram_data;

    logic [7:0] dev [16];
    logic [7:0] ref_mem [16];
    logic [7:0] exp_a = 0, exp_b = 0;
    logic park = 1;
    bit last_b = 1;
    int checks = 0, errors = 0, cyc = 0, last_gnt_cyc = 0, gap = 0;

    ram_arbiter #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk(clk), .reset(reset), .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
        .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .done_a(done_a), .done_b(done_b),
        .rdata_a(rdata_a), .rdata_b(rdata_b), .ram_we(ram_we), .ram_enable(ram_enable),
        .ram_addr(ram_addr), .ram_data(ram_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // External RAM; the bench parks the bus at 0 whenever the arbiter must be high-impedance.
    assign ram_data = (ram_enable && !ram_we) ? dev[ram_addr] : park ? 8'h00 : 8'hzz;
    always @(posedge clk) if (ram_we) dev[ram_addr] <= ram_data;

    always @(negedge clk) if (!reset) begin
        checks++;
        assert (!(ram_we && ram_enable)) else begin
            errors++;
            $error("FAIL we_en_exclusive: observed %0b%0b expected not both 1", ram_we, ram_enable);
        end
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Runs one complete transaction from an IDLE negedge with the current request inputs.
    task automatic serve(input bit keep);
        bit w;
        logic xwe;
        logic [3:0] xad;
        logic [7:0] xd;
        w   = (req_a && req_b) ? !last_b : req_b;
        xwe = w ? we_b : we_a;
        xad = w ? addr_b : addr_a;
        xd  = w ? wdata_b : wdata_a;
        park = !xwe;
        @(posedge clk); #1;
        chk("gnt_a_setup", 8'(gnt_a), 8'(!w));
        chk("gnt_b_setup", 8'(gnt_b), 8'(w));
        chk("done_setup", 8'({done_a, done_b}), 8'h00);
        chk("bus_setup", ram_data, xwe ? xd : 8'h00);
        gap = cyc - last_gnt_cyc;
        last_gnt_cyc = cyc;
        last_b = w;
        if (xwe) ref_mem[xad] = xd;
        else if (w) exp_b = ref_mem[xad];
        else exp_a = ref_mem[xad];
        if (w) begin we_b = 1'($urandom); addr_b = 4'($urandom); wdata_b = 8'($urandom); end
        else   begin we_a = 1'($urandom); addr_a = 4'($urandom); wdata_a = 8'($urandom); end
        if (!keep) begin req_a = 0; req_b = 0; end
        @(posedge clk); #1;
        chk("ram_we_access", 8'(ram_we), 8'(xwe));
        chk("ram_enable_access", 8'(ram_enable), 8'(!xwe));
        chk("ram_addr_access", 8'(ram_addr), 8'(xad));
        chk("bus_access", ram_data, xwe ? xd : ref_mem[xad]);
        chk("gnt_access", 8'({gnt_a, gnt_b}), 8'h00);
        @(posedge clk); #1;
        chk("done_a_resp", 8'(done_a), 8'(!w));
        chk("done_b_resp", 8'(done_b), 8'(w));
        chk("strobes_resp", 8'({ram_we, ram_enable}), 8'h00);
        chk("rdata_a", rdata_a, exp_a);
        chk("rdata_b", rdata_b, exp_b);
        chk("bus_resp", ram_data, xwe ? xd : 8'h00);
        @(posedge clk); #1;
        park = 1;
        #1;
        chk("bus_idle", ram_data, 8'h00);
        chk("gnt_done_idle", 8'({gnt_a, gnt_b, done_a, done_b}), 8'h00);
        chk("ram_addr_hold", 8'(ram_addr), 8'(xad));
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin dev[i] = 0; ref_mem[i] = 0; end
        repeat (2) @(negedge clk);
        chk("rst_gnt_done", 8'({gnt_a, gnt_b, done_a, done_b}), 8'h00);
        chk("rst_strobes", 8'({ram_we, ram_enable}), 8'h00);
        chk("rst_addr", 8'(ram_addr), 8'h00);
        chk("rst_rdata", rdata_a | rdata_b, 8'h00);
        chk("rst_bus", ram_data, 8'h00);
        reset = 0;

        req_a = 1; we_a = 1; addr_a = 3; wdata_a = 8'hA5;
        serve(0);
        req_b = 1; we_b = 0; addr_b = 3;
        serve(0);
        chk("b_read_a5", rdata_b, 8'hA5);

        reset = 1; #1; reset = 0; exp_a = 0; exp_b = 0; last_b = 1;
        req_a = 1; req_b = 1;
        for (int i = 0; i < 4; i++) begin
            serve(i < 3);
            chk("rr_order", 8'(last_b), 8'(i % 2));
            if (i > 0) chk("gnt_spacing", 8'(gap), 8'd4);
        end

        req_a = 1; we_a = 1; addr_a = 7; wdata_a = 8'h3C; park = 0;
        @(posedge clk); #1;
        chk("abort_gnt", 8'(gnt_a), 8'h01);
        req_a = 0;
        @(posedge clk); #1;
        chk("abort_we_before", 8'(ram_we), 8'h01);
        #2; reset = 1; park = 1; #1;
        chk("abort_we", 8'(ram_we), 8'h00);
        chk("abort_bus", ram_data, 8'h00);
        chk("abort_addr", 8'(ram_addr), 8'h00);
        chk("abort_flags", 8'({gnt_a, gnt_b, done_a, done_b, ram_enable}), 8'h00);
        @(negedge clk); reset = 0; exp_a = 0; exp_b = 0; last_b = 1;
        repeat (2) begin
            @(posedge clk); #1;
            chk("abort_no_done", 8'({done_a, done_b, gnt_a, gnt_b}), 8'h00);
        end
        @(negedge clk);
        req_b = 1; we_b = 1; addr_b = 7; wdata_b = 8'h5A;
        serve(0);

        for (int a = 0; a < 16; a++) begin
            if ($urandom_range(0, 1) == 1) begin req_b = 1; we_b = 1; addr_b = 4'(a); wdata_b = 8'(8'h10 + a); end
            else begin req_a = 1; we_a = 1; addr_a = 4'(a); wdata_a = 8'(8'h10 + a); end
            serve(0);
        end
        for (int a = 0; a < 16; a++) begin
            if ($urandom_range(0, 1) == 1) begin req_b = 1; we_b = 0; addr_b = 4'(a); end
            else begin req_a = 1; we_a = 0; addr_a = 4'(a); end
            serve(0);
            chk("sweep_read", last_b ? rdata_b : rdata_a, 8'(8'h10 + a));
        end

        for (int n = 0; n < 40; n++) begin
            int rv;
            rv = $urandom_range(0, 3);
            we_a = 1'($urandom); addr_a = 4'($urandom); wdata_a = 8'($urandom);
            we_b = 1'($urandom); addr_b = 4'($urandom); wdata_b = 8'($urandom);
            if (rv == 0) begin
                @(posedge clk); #1;
                chk("no_req_idle", 8'({gnt_a, gnt_b}), 8'h00);
                chk("no_req_bus", ram_data, 8'h00);
                @(negedge clk);
            end else begin
                req_a = rv[0];
                req_b = rv[1];
                serve(0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the data width of requester ports and RAM bus.
REQ-002 Parameter ADDR_W, default 4, SHALL set the address width (16 locations).
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 reset  input  1  SHALL be asynchronous, active-high reset.
REQ-005 req_a / req_b  input  1  SHALL be the access request from requester A / B.
REQ-006 we_a / we_b  input  1  SHALL select 1=write, 0=read.
REQ-007 addr_a / addr_b  input  ADDR_W  SHALL be the target location.
REQ-008 wdata_a / wdata_b  input  DATA_W  SHALL be the write data.
REQ-009 gnt_a / gnt_b  output  1  SHALL pulse for one cycle when that requester's command is latched.
REQ-010 done_a / done_b  output  1  SHALL pulse for one cycle when that requester's access completes.
REQ-011 rdata_a / rdata_b  output  DATA_W  SHALL hold that requester's last read result.
REQ-012 ram_we  output  1  SHALL drive RAM we (RAM writes while we=1, enable=0).
REQ-013 ram_enable  output  1  SHALL drive RAM enable (RAM drives bus while enable=1, we=0).
REQ-014 ram_addr  output  ADDR_W  SHALL drive the RAM address.
REQ-015 ram_data  inout  DATA_W  SHALL be the shared RAM data bus.

Function
REQ-016 FSM states SHALL be IDLE, SETUP, ACCESS, RESP; transitions SETUP->ACCESS->RESP->IDLE unconditional, one cycle each.
REQ-017 req_a/req_b SHALL be sampled only in IDLE; with any request high, FSM SHALL go to SETUP and latch winner's we, addr, wdata.
REQ-018 Arbitration SHALL be round-robin: both requesting -> requester not served last wins; single requester wins regardless.
REQ-019 gnt_x SHALL be high exactly during the SETUP cycle of requester x's transaction; done_x exactly during its RESP cycle.
REQ-020 ram_addr SHALL equal the latched address from SETUP through RESP and hold its value in IDLE.
REQ-021 Write: ram_data SHALL be driven with latched wdata during SETUP, ACCESS, RESP; ram_we=1 only during ACCESS.
REQ-022 Read: ram_data SHALL be high-impedance; ram_enable=1 only during ACCESS; ram_data SHALL be captured into rdata_x at the end of ACCESS.
REQ-023 ram_data SHALL be high-impedance in IDLE and throughout any read transaction.
REQ-024 ram_we and ram_enable SHALL never be high simultaneously; both SHALL be registered (glitch-free).
REQ-025 Latency: gnt one cycle after req sampled in IDLE; done two cycles after gnt; one transaction per 4 cycles.
REQ-026 Requester SHALL hold command stable until gnt; changes after gnt SHALL not affect the transaction.
REQ-027 A requester dropping req in its done cycle SHALL not be re-granted; req still high in next IDLE SHALL start a new transaction.
REQ-028 rdata_x of the non-served requester and after writes SHALL be unchanged.
REQ-029 Address SHALL be used as-is; 15 is valid, no wrap or increment.

Reset
REQ-030 reset=1 SHALL immediately force state IDLE, ram_we=0, ram_enable=0, ram_data high-impedance, gnt/done=0, ram_addr=0, rdata_a=rdata_b=0, round-robin last-served=B (A priority next).
REQ-031 Reset during any state SHALL abort the transaction without done; content of a location whose write was aborted in ACCESS is undefined.

Verification
REQ-032 After reset, A write addr 3 data 8'hA5 -> gnt_a next cycle, ram_we high one cycle with ram_addr=3, ram_data=8'hA5, done_a two cycles after gnt_a.
REQ-033 Then B read addr 3 -> ram_enable high one cycle, bus z from arbiter, done_b with rdata_b=8'hA5, rdata_a unchanged.
REQ-034 req_a and req_b held high from reset for 4 transactions -> grant order A,B,A,B, gnt pulses 4 cycles apart.
REQ-035 Reset asserted mid-ACCESS of a write -> ram_we=0 same cycle, bus z, no done_x, next request served from IDLE normally.
REQ-036 Write addr 0..15 with data 8'h10+addr, read all back -> every rdata matches; ram_we&ram_enable never both 1; bus z in every IDLE cycle.
